// File: rtl/instr_enc_pkg.sv
// Shared constants for the instruction encoder: format codes, branch/jump
// opcodes that need a delay-slot pad, and the instruction-memory base address.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_J   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    localparam logic [5:0]  OP_BEQ  = 6'h04;
    localparam logic [5:0]  OP_J    = 6'h02;
    localparam logic [5:0]  OP_JAL  = 6'h03;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_BASE = 32'h0000_3000;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words; the head reads as zero
// while empty so the downstream word is well defined after reset.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage has no reset; occupancy is tracked by count, and stale
    // entries are never observable because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_enc.sv
// Packs decoded MIPS fields into R/I/J words, queues them and emits them with
// sequential IM addresses. Optional delay-slot NOP padding: INSTR_ENC_DELAY_SLOT_EN.
module instr_enc
    import instr_enc_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = PC_BASE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   fmt,
    input  logic [5:0]                   opcode,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [4:0]                   shamt,
    input  logic [5:0]                   funct,
    input  logic [15:0]                  imm16,
    input  logic [25:0]                  index26,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [31:0]                  out_addr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0] enc_word;
    logic [31:0] push_word;
    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;

    always_comb begin
        enc_word = '0;
        case (fmt_e'(fmt))
            FMT_R:   enc_word = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   enc_word = {opcode, rs, rt, imm16};
            FMT_J:   enc_word = {opcode, index26};
            default: enc_word = '0;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign legal  = (fmt_e'(fmt) != FMT_BAD);

`ifdef INSTR_ENC_DELAY_SLOT_EN
    logic pad_pending;
    logic needs_pad;

    assign needs_pad = (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_JAL);

    // Keeping a spare slot guarantees the pad NOP always fits on the next cycle.
    assign in_ready  = (count <= CW'(DEPTH-2)) && !pad_pending;
    assign push      = pad_pending || (accept && legal);
    assign push_word = pad_pending ? NOP : enc_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pad_pending <= 1'b0;
        end else begin
            pad_pending <= accept && legal && needs_pad;
        end
    end
`else
    assign in_ready  = (count < CW'(DEPTH));
    assign push      = accept && legal;
    assign push_word = enc_word;
`endif

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_word),
        .pop   (pop),
        .dout  (out_instr),
        .count (count)
    );

    // The address belongs to the head word, so it only advances when a word leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_addr <= BASE_ADDR;
            err      <= 1'b0;
        end else begin
            if (pop)               out_addr <= out_addr + 32'd4;
            if (accept && !legal)  err      <= 1'b1;
        end
    end

endmodule
